// File: rtl/noc_params.sv
// ----------------------------------------------------------------------------
// noc_params
// Shared router parameters: port count, VCs per port, index widths and the
// output-port encoding used by every router block.
// ----------------------------------------------------------------------------
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 4;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL,
        NORTH,
        SOUTH,
        WEST,
        EAST
    } port_t;

endpackage

// File: rtl/vc_allocator_if.sv
// ----------------------------------------------------------------------------
// input_block2vc_allocator
// Request/grant bundle between the input blocks and the VC allocator.
//   out_port   : requested output port per upstream (port, VC)
//   vc_request : request for a downstream VC per upstream (port, VC)
//   vc_new     : allocated downstream VC index (meaningful only with vc_valid)
//   vc_valid   : grant per upstream (port, VC)
// Modports: input_block (requesting side), vc_allocator (granting side).
// ----------------------------------------------------------------------------
interface input_block2vc_allocator;
    import noc_params::*;

    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              vc_request;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid;

    modport input_block (
        output out_port,
        output vc_request,
        input  vc_new,
        input  vc_valid
    );

    modport vc_allocator (
        input  out_port,
        input  vc_request,
        output vc_new,
        output vc_valid
    );

endinterface

// File: rtl/vc_allocator.sv
// ----------------------------------------------------------------------------
// vc_allocator
// Separable input-first VC allocator. Each cycle every input port picks one
// requesting VC round-robin (only requests whose target port still has a free
// downstream VC qualify), then every output port picks one of the input-port
// candidates aimed at it round-robin. The winner gets the lowest-index free
// downstream VC of its target port. Downstream VC availability is tracked here:
// a grant consumes a VC, an idle indication on a consumed VC frees it again.
//
// Ports:
//   clk                  : clock, all state on its rising edge
//   rst                  : synchronous active-low reset
//   idle_downstream_vc_i : downstream VC [port][vc] has drained and is idle
//   ib_if                : request/grant bundle (vc_allocator modport)
// ----------------------------------------------------------------------------
module vc_allocator
    import noc_params::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]  idle_downstream_vc_i,
    input_block2vc_allocator.vc_allocator    ib_if
);

    // Index of the lowest set bit (0 when empty; callers qualify with OR).
    function automatic logic [VC_SIZE-1:0] lowest_set(input logic [VC_NUM-1:0] vec);
        lowest_set = '0;
        for (int d = VC_NUM - 1; d >= 0; d--) begin
            if (vec[d]) begin
                lowest_set = VC_SIZE'(d);
            end
        end
    endfunction

    // First set bit at or after ptr, wrapping modulo VC_NUM.
    function automatic logic [VC_SIZE-1:0] rr_vc(input logic [VC_NUM-1:0] vec,
                                                 input logic [VC_SIZE-1:0] ptr);
        logic found;
        int   idx;
        rr_vc = ptr;
        found = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(ptr) + i) % VC_NUM;
            if (!found && vec[idx]) begin
                rr_vc = VC_SIZE'(idx);
                found = 1'b1;
            end
        end
    endfunction

    // First set bit at or after ptr, wrapping modulo PORT_NUM.
    function automatic logic [PORT_SIZE-1:0] rr_ip(input logic [PORT_NUM-1:0] vec,
                                                   input logic [PORT_SIZE-1:0] ptr);
        logic found;
        int   idx;
        rr_ip = ptr;
        found = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            idx = (int'(ptr) + i) % PORT_NUM;
            if (!found && vec[idx]) begin
                rr_ip = PORT_SIZE'(idx);
                found = 1'b1;
            end
        end
    endfunction

    // State
    logic [PORT_NUM-1:0][VC_NUM-1:0]    avail_q,  avail_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_ptr_q, vc_ptr_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] ip_ptr_q, ip_ptr_d;

    // Per output port availability summary
    logic [PORT_NUM-1:0]                port_free;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   first_free;

    // Input stage results
    logic [PORT_NUM-1:0]                in_win_valid;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_win_vc;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  in_win_oh;     // candidate's target, one-hot

    // Output stage results
    logic [PORT_NUM-1:0]                out_win_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_win_ip;

    // Final grant per input port
    logic [PORT_NUM-1:0]                grant;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   grant_vc_new;

    genvar gi;

    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_avail
            assign port_free[gi]  = |avail_q[gi];
            assign first_free[gi] = lowest_set(avail_q[gi]);
        end

        for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
            logic [VC_NUM-1:0]               req_vec;
            logic [VC_NUM-1:0][PORT_NUM-1:0] tgt_oh;

            // Decoding the target to one-hot keeps out-of-range encodings from
            // ever qualifying a request.
            always_comb begin
                for (int v = 0; v < VC_NUM; v++) begin
                    tgt_oh[v] = '0;
                    for (int o = 0; o < PORT_NUM; o++) begin
                        if (int'(ib_if.out_port[gi][v]) == o) begin
                            tgt_oh[v][o] = 1'b1;
                        end
                    end
                    req_vec[v] = ib_if.vc_request[gi][v] && (|(tgt_oh[v] & port_free));
                end
            end

            assign in_win_valid[gi] = |req_vec;
            assign in_win_vc[gi]    = rr_vc(req_vec, vc_ptr_q[gi]);
            assign in_win_oh[gi]    = tgt_oh[in_win_vc[gi]];
        end

        for (gi = 0; gi < PORT_NUM; gi++) begin : g_out
            logic [PORT_NUM-1:0] req_vec;

            always_comb begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    req_vec[p] = in_win_valid[p] && in_win_oh[p][gi];
                end
            end

            assign out_win_valid[gi] = |req_vec;
            assign out_win_ip[gi]    = rr_ip(req_vec, ip_ptr_q[gi]);
        end

        for (gi = 0; gi < PORT_NUM; gi++) begin : g_grant
            logic [PORT_NUM-1:0] won;
            logic [VC_SIZE-1:0]  new_vc;

            always_comb begin
                won    = '0;
                new_vc = '0;
                for (int o = 0; o < PORT_NUM; o++) begin
                    won[o] = out_win_valid[o] && (int'(out_win_ip[o]) == gi) && in_win_oh[gi][o];
                    if (in_win_oh[gi][o]) begin
                        new_vc = first_free[o];
                    end
                end
            end

            // Grants are suppressed while reset is held.
            assign grant[gi]        = rst && (|won);
            assign grant_vc_new[gi] = new_vc;
        end
    endgenerate

    // Outputs: vc_new is don't-care wherever vc_valid is low.
    always_comb begin
        ib_if.vc_valid = '0;
        ib_if.vc_new   = 'x;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (grant[p]) begin
                ib_if.vc_valid[p][in_win_vc[p]] = 1'b1;
                ib_if.vc_new[p][in_win_vc[p]]   = grant_vc_new[p];
            end
        end
    end

    // Next state. Recovery looks at avail_q, so a VC consumed this cycle is
    // never restored by the same edge.
    always_comb begin
        avail_d  = avail_q;
        vc_ptr_d = vc_ptr_q;
        ip_ptr_d = ip_ptr_q;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (out_win_valid[o]) begin
                avail_d[o][first_free[o]] = 1'b0;
                ip_ptr_d[o] = (out_win_ip[o] == PORT_SIZE'(PORT_NUM - 1)) ?
                              '0 : out_win_ip[o] + PORT_SIZE'(1);
            end
            avail_d[o] = avail_d[o] | (~avail_q[o] & idle_downstream_vc_i[o]);
        end
        // The input pointer advances even if the candidate loses downstream.
        for (int p = 0; p < PORT_NUM; p++) begin
            if (in_win_valid[p]) begin
                vc_ptr_d[p] = (in_win_vc[p] == VC_SIZE'(VC_NUM - 1)) ?
                              '0 : in_win_vc[p] + VC_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            avail_q  <= '1;
            vc_ptr_q <= '0;
            ip_ptr_q <= '0;
        end else begin
            avail_q  <= avail_d;
            vc_ptr_q <= vc_ptr_d;
            ip_ptr_q <= ip_ptr_d;
        end
    end

endmodule

// File: tb/tb_vc_allocator.sv
`timescale 1ns/1ps
module tb_vc_allocator;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    logic [PORT_NUM-1:0][VC_NUM-1:0] idle;

    input_block2vc_allocator ib();

    vc_allocator dut (
        .clk                  (clk),
        .rst                  (rst),
        .idle_downstream_vc_i (idle),
        .ib_if                (ib)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                                         cyc;
        logic [PORT_NUM-1:0][VC_NUM-1:0]              valid;
        logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vnew;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state (reset values match the state after reset).
    bit m_avail [PORT_NUM][VC_NUM];
    int m_vptr  [PORT_NUM];
    int m_iptr  [PORT_NUM];
    int m_cand  [PORT_NUM];   // input-stage candidate VC, -1 when none
    int m_win   [PORT_NUM];   // output-stage winning input port, -1 when none

    function automatic bit has_free(input int o);
        bit r = 0;
        for (int d = 0; d < VC_NUM; d++) r |= m_avail[o][d];
        return r;
    endfunction

    function automatic int lowest_free(input int o);
        for (int d = 0; d < VC_NUM; d++) if (m_avail[o][d]) return d;
        return -1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int d = 0; d < VC_NUM; d++) m_avail[o][d] = 1'b1;
            m_vptr[o] = 0;
            m_iptr[o] = 0;
        end
    endtask

    task automatic model_eval(output exp_t e);
        int v, t, p;
        e.cyc   = cyc;
        e.valid = '0;
        e.vnew  = '0;
        for (int pp = 0; pp < PORT_NUM; pp++) begin
            m_cand[pp] = -1;
            for (int i = 0; i < VC_NUM; i++) begin
                if (m_cand[pp] < 0) begin
                    v = (m_vptr[pp] + i) % VC_NUM;
                    t = int'(ib.out_port[pp][v]);
                    if (ib.vc_request[pp][v] === 1'b1 && t < PORT_NUM && has_free(t))
                        m_cand[pp] = v;
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            m_win[o] = -1;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (m_win[o] < 0) begin
                    p = (m_iptr[o] + i) % PORT_NUM;
                    if (m_cand[p] >= 0 && int'(ib.out_port[p][m_cand[p]]) == o)
                        m_win[o] = p;
                end
            end
        end
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (m_win[o] >= 0) begin
                    p = m_win[o];
                    e.valid[p][m_cand[p]] = 1'b1;
                    e.vnew[p][m_cand[p]]  = VC_SIZE'(lowest_free(o));
                end
            end
        end
    endtask

    task automatic model_update();
        bit old [PORT_NUM][VC_NUM];
        if (!rst) begin
            model_reset();
        end else begin
            old = m_avail;
            for (int o = 0; o < PORT_NUM; o++) begin
                if (m_win[o] >= 0) begin
                    m_avail[o][lowest_free(o)] = 1'b0;
                    m_iptr[o] = (m_win[o] + 1) % PORT_NUM;
                end
            end
            for (int o = 0; o < PORT_NUM; o++)
                for (int d = 0; d < VC_NUM; d++)
                    if (!old[o][d] && idle[o][d]) m_avail[o][d] = 1'b1;
            for (int p = 0; p < PORT_NUM; p++)
                if (m_cand[p] >= 0) m_vptr[p] = (m_cand[p] + 1) % VC_NUM;
        end
    endtask

    // Inputs are set just after a rising edge; tick() records the expectation
    // and moves to the sampling point, advance() commits the model and crosses
    // the next rising edge.
    task automatic tick();
        exp_t e;
        model_eval(e);
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        ib.vc_request = '0;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) ib.out_port[p][v] = LOCAL;
        idle = '0;
    endtask

    task automatic reset_cycle();
        clear_inputs();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (ib.vc_valid !== '0) begin
            n_err++;
            $display("FAIL reset_valid cyc=%0d got=%h want=0", cyc, ib.vc_valid);
        end
        advance();
        rst = 1'b1;
    endtask

    // Scoreboard: compares DUT outputs against the queued expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            if (ib.vc_valid !== mon_e.valid) begin
                n_err++;
                $display("FAIL sb_valid cyc=%0d got=%h want=%h", mon_e.cyc, ib.vc_valid, mon_e.valid);
            end
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (mon_e.valid[p][v]) begin
                        n_cmp++;
                        if (ib.vc_new[p][v] !== mon_e.vnew[p][v]) begin
                            n_err++;
                            $display("FAIL sb_vc_new cyc=%0d p=%0d v=%0d got=%0d want=%0d",
                                     mon_e.cyc, p, v, ib.vc_new[p][v], mon_e.vnew[p][v]);
                        end
                    end
                end
            end
            $display("cyc %0d rst=%0b req=%h valid=%h", mon_e.cyc, rst, ib.vc_request, ib.vc_valid);
        end
    end

    task automatic test_reset();
        reset_cycle();
        tick();                                  // idle after reset
        n_cmp++;
        if (ib.vc_valid !== '0) begin
            n_err++;
            $display("FAIL idle_valid got=%h want=0", ib.vc_valid);
        end
        advance();
        ib.vc_request[3][2] = 1'b1;
        ib.out_port[3][2]   = SOUTH;
        tick();
        n_cmp++;
        if (ib.vc_valid[3][2] !== 1'b1 || ib.vc_new[3][2] !== VC_SIZE'(0)) begin
            n_err++;
            $display("FAIL first_grant got valid=%0b new=%0d want valid=1 new=0",
                     ib.vc_valid[3][2], ib.vc_new[3][2]);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_single();
        clear_inputs();
        ib.vc_request[1][0] = 1'b1;
        ib.out_port[1][0]   = EAST;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (ib.vc_valid[1][0] !== 1'b1 || ib.vc_new[1][0] !== VC_SIZE'(k)) begin
                n_err++;
                $display("FAIL single_%0d got valid=%0b new=%0d want valid=1 new=%0d",
                         k, ib.vc_valid[1][0], ib.vc_new[1][0], k);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_contention();
        int wp, wv;
        reset_cycle();
        ib.vc_request = '1;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) ib.out_port[p][v] = NORTH;
        idle = '1;
        for (int c = 0; c < 10; c++) begin
            tick();
            // every port's candidate advances each cycle, so the winner VC is c mod VC_NUM
            wp = c % PORT_NUM;
            wv = c % VC_NUM;
            n_cmp++;
            if ($countones(ib.vc_valid) != 1 || ib.vc_valid[wp][wv] !== 1'b1) begin
                n_err++;
                $display("FAIL contention c=%0d got=%h want only p=%0d v=%0d", c, ib.vc_valid, wp, wv);
            end
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_exhaustion();
        reset_cycle();
        ib.vc_request = '1;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) ib.out_port[p][v] = (p < 3) ? WEST : EAST;
        idle = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if ($countones(ib.vc_valid) != ((c < VC_NUM) ? 2 : 0)) begin
                n_err++;
                $display("FAIL exhaustion c=%0d got=%0d want=%0d", c,
                         $countones(ib.vc_valid), (c < VC_NUM) ? 2 : 0);
            end
            advance();
        end
    endtask

    task automatic test_recovery();
        idle = '1;                               // requests kept from exhaustion
        tick();
        n_cmp++;
        if (ib.vc_valid !== '0) begin
            n_err++;
            $display("FAIL recovery_same_cycle got=%h want=0", ib.vc_valid);
        end
        advance();
        tick();
        n_cmp++;
        if ($countones(ib.vc_valid) != 2) begin
            n_err++;
            $display("FAIL recovery_count got=%0d want=2", $countones(ib.vc_valid));
        end
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++)
                if (ib.vc_valid[p][v] === 1'b1) begin
                    n_cmp++;
                    if (ib.vc_new[p][v] !== VC_SIZE'(0)) begin
                        n_err++;
                        $display("FAIL recovery_lowest p=%0d v=%0d got=%0d want=0", p, v, ib.vc_new[p][v]);
                    end
                end
        advance();
        for (int c = 0; c < 3; c++) begin
            tick();
            advance();
        end
        clear_inputs();
    endtask

    task automatic test_random_reset();
        for (int c = 0; c < 40; c++) begin
            ib.vc_request = (PORT_NUM*VC_NUM)'($urandom);
            for (int p = 0; p < PORT_NUM; p++)
                for (int v = 0; v < VC_NUM; v++)
                    ib.out_port[p][v] = port_t'($urandom_range(0, PORT_NUM - 1));
            idle = (PORT_NUM*VC_NUM)'($urandom) & (PORT_NUM*VC_NUM)'($urandom);
            rst  = (c == 15 || c == 30) ? 1'b0 : 1'b1;
            tick();
            if (!rst) begin
                n_cmp++;
                if (ib.vc_valid !== '0) begin
                    n_err++;
                    $display("FAIL random_rst_valid c=%0d got=%h want=0", c, ib.vc_valid);
                end
            end
            advance();
        end
        rst = 1'b1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_exhaustion();
        test_recovery();
        test_random_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain got=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
